mult32_seq: RTL and testbench

Sequential unsigned 32×32→64 multiplier controller built around the team's existing 32-bit ripple adder `adder32bit`. The block sequences that single adder through 32 shift-add iterations under a start/busy/done handshake. It sits beside the ALU as the multi-cycle execution unit for `MULTU`. It also serves as the template for later iterative units such as the divider.

---
 rtl/mult_pkg.sv | 12 +
 rtl/adder32bit.sv | 27 ++
 rtl/mult32_seq.sv | 97 +++++++++
 tb/tb_mult32_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the iterative multiply unit: FSM encoding and iteration count.
package mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mult_state_t;

  localparam int MULT_ITERS = 32;

endpackage

// File: rtl/adder32bit.sv
// 32-bit ripple-carry adder with carry-out and signed-overflow flag.
module adder32bit #(
  parameter int WIDTH = 32
) (
  input  logic             c_in,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             v
);

  logic [WIDTH:0] w_c;

  assign w_c[0] = c_in;

  // One full-adder cell per bit, carry rippling upward.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    assign sum[gi]     = x[gi] ^ y[gi] ^ w_c[gi];
    assign w_c[gi + 1] = (x[gi] & y[gi]) | (w_c[gi] & (x[gi] ^ y[gi]));
  end

  assign c_out = w_c[WIDTH];
  // Overflow when the carry into the sign bit differs from the carry out of it.
  assign v     = w_c[WIDTH] ^ w_c[WIDTH-1];

endmodule

// File: rtl/mult32_seq.sv
// Sequential unsigned 32x32->64 shift-add multiplier. One shared ripple adder
// is stepped through 32 iterations; start/busy/done handshake.
module mult32_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32  // must match the adder32bit width; only 32 is supported
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [4:0] LAST_CNT = 5'(MULT_ITERS - 1);

  mult_state_t        r_state;
  mult_state_t        w_state_next;
  logic [WIDTH-1:0]   r_m;
  // Product/multiplier shift register {hi, lo}. The adder carry is shifted
  // straight into hi[31] each step, so the top "carry" bit of the 65-bit
  // working value is always zero after a shift and need not be stored.
  logic [2*WIDTH-1:0] r_p;
  logic [4:0]         r_cnt;

  logic [WIDTH-1:0]   w_sum;
  logic               w_c_out;
  logic               w_v_unused;

  adder32bit #(
    .WIDTH(WIDTH)
  ) u_adder (
    .c_in (1'b0),
    .x    (r_p[2*WIDTH-1:WIDTH]),
    .y    (r_m),
    .sum  (w_sum),
    .c_out(w_c_out),
    .v    (w_v_unused)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: start only matters in IDLE; DONE lasts one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_next = S_RUN;
      S_RUN:  if (r_cnt == LAST_CNT) w_state_next = S_DONE;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one shift-add step per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m   <= '0;
      r_p   <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m   <= x;
            r_p   <= {{WIDTH{1'b0}}, y};
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          if (r_p[0]) begin
            r_p <= {w_c_out, w_sum, r_p[WIDTH-1:1]};
          end else begin
            r_p <= {1'b0, r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs are pure decodes of the state register.
  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign product = r_p;

endmodule

// File: tb/tb_mult32_seq.sv
// Directed self-checking bench for mult32_seq.
module tb_mult32_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] x;
  logic [31:0] y;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int n_checks;
  int n_bad;

  mult32_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x      (x),
    .y      (y),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Single-pulse multiply; checks latency, busy length, exclusivity and result.
  task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
    int lat;
    int busy_cycles;
    int overlap;
    lat = 0;
    busy_cycles = 0;
    overlap = 0;
    @(negedge clk);
    x = a;
    y = b;
    start = 1'b1;
    @(posedge clk);  // E0
    #1;
    start = 1'b0;
    if (busy) busy_cycles++;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cycles++;
      if (busy && done) overlap++;
      if (done) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'd32);
    chk({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd32);
    chk({tag, "_busy_done_overlap"}, 64'(overlap), 64'd0);
    chk({tag, "_product"}, product, exp);
    @(posedge clk);
    #1;
    chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    chk({tag, "_product_held"}, product, exp);
  endtask

  initial begin
    int dones;
    int first_done;
    int second_done;
    n_checks = 0;
    n_bad = 0;
    rst = 1'b1;
    start = 1'b0;
    x = '0;
    y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_product", product, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_mult("small_3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
    do_mult("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    do_mult("zero_x", 32'h0, 32'h1234_5678, 64'h0);
    do_mult("msb_x2", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);

    // Start while busy: second request at E10 must be dropped.
    dones = 0;
    first_done = 0;
    @(negedge clk);
    x = 32'd7;
    y = 32'd9;
    start = 1'b1;
    @(posedge clk);  // E0
    #1;
    start = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      if (n == 10) begin
        x = 32'd100;
        y = 32'd100;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      if (n == 10) start = 1'b0;
      if (done) begin
        dones++;
        if (first_done == 0) begin
          first_done = n;
          chk("busy_start_product", product, 64'd63);
        end
      end
    end
    chk("busy_start_done_cnt", 64'(dones), 64'd1);
    chk("busy_start_latency", 64'(first_done), 64'd32);

    // Reset in the middle of an operation.
    @(negedge clk);
    x = 32'd11;
    y = 32'd13;
    start = 1'b1;
    @(posedge clk);  // E0
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_product", product, 64'd0);
    dones = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("rst_mid_no_done", 64'(dones), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_mult("after_rst_6x7", 32'd6, 32'd7, 64'd42);

    // Back-to-back with start held high.
    first_done = 0;
    second_done = 0;
    dones = 0;
    @(negedge clk);
    x = 32'd2;
    y = 32'd3;
    start = 1'b1;
    @(posedge clk);  // E0
    #1;
    x = 32'd4;
    y = 32'd5;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk);
      #1;
      if (n == 33) chk("b2b_product_held", product, 64'd6);
      if (done) begin
        dones++;
        if (first_done == 0) begin
          first_done = n;
          chk("b2b_first_product", product, 64'd6);
        end else if (second_done == 0) begin
          second_done = n;
          chk("b2b_second_product", product, 64'd20);
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_first_edge", 64'(first_done), 64'd32);
    chk("b2b_second_edge", 64'(second_done), 64'd66);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
